// File: rtl/peripheral_status_sampler_pkg.sv
// Shared peripheral types and sizing constants for the status input path.
package peripherals;

    localparam int unsigned NUM_BUTTONS             = 5;
    localparam int unsigned NUM_SWITCHES            = 16;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Button order as packed on the board header: center is the MSB.
    typedef struct packed {
        logic center;
        logic left;
        logic right;
        logic up;
        logic down;
    } buttons_t;

    // Status word read by the CPU: buttons in bits 20:16, switches in 15:0.
    typedef struct packed {
        buttons_t    button_state;
        logic [15:0] switch_state;
    } peripheral_status_bus_t;

endpackage : peripherals

// File: rtl/peripheral_status_sampler_debounce_bit.sv
// One input bit: metastability synchroniser followed by a restart-on-bounce
// debounce counter. The stable value only flips after the synchronised input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    // Plain flop chain, nothing between stages, to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Count consecutive disagreement; any agreement restarts from zero.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce counter and stable value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule : debounce_bit

// File: rtl/peripheral_status_sampler.sv
// Board button/switch sampler: debounces every raw pin, registers the packed
// status word and derives button press pulses, sticky press flags (W1C) and
// a status-changed pulse aligned with the new status value.
module peripheral_status_sampler
    import peripherals::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_BUTTONS-1:0]           btn_raw,
    input  logic [NUM_SWITCHES-1:0]          sw_raw,
    output peripheral_status_bus_t           status,
    output logic [NUM_BUTTONS-1:0]           btn_press_pulse,
    output logic [NUM_BUTTONS-1:0]           btn_press_sticky,
    input  logic [NUM_BUTTONS-1:0]           sticky_clear,
    output logic                             status_changed
);

    localparam int unsigned NUM_BITS = NUM_BUTTONS + NUM_SWITCHES;

    logic [NUM_BITS-1:0]    raw_s;
    logic [NUM_BITS-1:0]    stable_s;
    logic [NUM_BUTTONS-1:0] stable_btn_s;
    logic [NUM_BUTTONS-1:0] status_btn_s;

    peripheral_status_bus_t status_q;
    peripheral_status_bus_t status_d;
    logic [NUM_BUTTONS-1:0] pulse_q;
    logic [NUM_BUTTONS-1:0] pulse_d;
    logic [NUM_BUTTONS-1:0] sticky_q;
    logic [NUM_BUTTONS-1:0] sticky_d;
    logic                   changed_q;
    logic                   changed_d;

    // Bit layout of raw_s matches the status bus so index i maps straight through.
    assign raw_s = {btn_raw, sw_raw};

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_debounce_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (raw_s[i]),
            .stable_o (stable_s[i])
        );
    end

    assign stable_btn_s = stable_s[NUM_BITS-1:NUM_SWITCHES];
    assign status_btn_s = status_q.button_state;

    // Press = debounced rising edge of a button; the sticky set wins over clear.
    always_comb begin
        status_d  = stable_s;
        pulse_d   = stable_btn_s & ~status_btn_s;
        sticky_d  = (sticky_q & ~sticky_clear) | pulse_d;
        changed_d = |(stable_s ^ NUM_BITS'(status_q));
    end

    // Output registers; everything the CPU sees comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q  <= '0;
            pulse_q   <= '0;
            sticky_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            pulse_q   <= pulse_d;
            sticky_q  <= sticky_d;
            changed_q <= changed_d;
        end
    end

    assign status           = status_q;
    assign btn_press_pulse  = pulse_q;
    assign btn_press_sticky = sticky_q;
    assign status_changed   = changed_q;

endmodule : peripheral_status_sampler

// File: tb/tb_peripheral_status_sampler.sv
// Directed bench for peripheral_status_sampler with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2: a held raw step shows on status 6 edges after first sampling.
module tb_peripheral_status_sampler;
    import peripherals::*;

    logic                   clk;
    logic                   rst_n;
    logic [4:0]             btn_raw;
    logic [15:0]            sw_raw;
    peripheral_status_bus_t status;
    logic [4:0]             btn_press_pulse;
    logic [4:0]             btn_press_sticky;
    logic [4:0]             sticky_clear;
    logic                   status_changed;

    int checks_r;
    int errors_r;
    int chg_cnt_r;
    int pulse_cnt_r;

    peripheral_status_sampler #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .btn_raw          (btn_raw),
        .sw_raw           (sw_raw),
        .status           (status),
        .btn_press_pulse  (btn_press_pulse),
        .btn_press_sticky (btn_press_sticky),
        .sticky_clear     (sticky_clear),
        .status_changed   (status_changed)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle; also tally event pulses seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (status_changed === 1'b1) chg_cnt_r++;
        if (btn_press_pulse !== 5'b00000) pulse_cnt_r++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        ticks(2);
        rst_n = 1'b1;
    endtask

    initial begin
        checks_r     = 0;
        errors_r     = 0;
        chg_cnt_r    = 0;
        pulse_cnt_r  = 0;
        rst_n        = 1'b0;
        btn_raw      = 5'b11111;
        sw_raw       = 16'hFFFF;
        sticky_clear = 5'b00000;

        // Reset state with every pin high.
        #2;
        check_eq("rst_status", status, 21'h000000);
        check_eq("rst_pulse", 21'(btn_press_pulse), 21'h0);
        check_eq("rst_sticky", 21'(btn_press_sticky), 21'h0);
        check_eq("rst_changed", 21'(status_changed), 21'h0);
        btn_raw = 5'b00000;
        sw_raw  = 16'h0000;
        apply_reset();

        // Clean press of center.
        btn_raw = 5'b10000;
        ticks(6);
        check_eq("press_early", status, 21'h000000);
        chg_cnt_r = 0;
        tick();
        check_eq("press_status", status, 21'h100000);
        check_eq("press_pulse", 21'(btn_press_pulse), 21'h10);
        check_eq("press_sticky", 21'(btn_press_sticky), 21'h10);
        check_eq("press_changed", 21'(status_changed), 21'h1);
        tick();
        check_eq("press_pulse_end", 21'(btn_press_pulse), 21'h0);
        check_eq("press_changed_end", 21'(status_changed), 21'h0);
        check_eq("press_sticky_hold", 21'(btn_press_sticky), 21'h10);
        check_eq("press_chg_count", 21'(chg_cnt_r), 21'd1);

        // Bounce rejection on switch 3.
        btn_raw = 5'b00000;
        sw_raw  = 16'h0000;
        apply_reset();
        chg_cnt_r = 0;
        sw_raw = 16'h0008; tick();
        sw_raw = 16'h0000; tick();
        sw_raw = 16'h0008; tick();
        sw_raw = 16'h0000; tick();
        sw_raw = 16'h0008;
        ticks(6);
        check_eq("bounce_hold", status, 21'h000000);
        tick();
        check_eq("bounce_status", status, 21'h000008);
        ticks(3);
        check_eq("bounce_chg_count", 21'(chg_cnt_r), 21'd1);
        check_eq("bounce_no_pulse", 21'(btn_press_sticky), 21'h0);

        // Sticky clear racing the press of up.
        sw_raw = 16'h0000;
        apply_reset();
        btn_raw = 5'b00010;
        ticks(6);
        sticky_clear = 5'b00010;
        tick();
        check_eq("race_pulse", 21'(btn_press_pulse), 21'h02);
        check_eq("race_sticky_set_wins", 21'(btn_press_sticky), 21'h02);
        tick();
        check_eq("race_sticky_cleared", 21'(btn_press_sticky), 21'h00);
        sticky_clear = 5'b00010;
        tick();
        check_eq("race_clear_idle", 21'(btn_press_sticky), 21'h00);
        sticky_clear = 5'b00000;

        // Simultaneous switch and button changes.
        btn_raw = 5'b00000;
        apply_reset();
        sw_raw  = 16'hFFFF;
        btn_raw = 5'b00011;
        chg_cnt_r = 0;
        ticks(7);
        check_eq("simul_status", status, 21'h03FFFF);
        check_eq("simul_pulse", 21'(btn_press_pulse), 21'h03);
        check_eq("simul_sticky", 21'(btn_press_sticky), 21'h03);
        ticks(2);
        check_eq("simul_chg_count", 21'(chg_cnt_r), 21'd1);

        // Release of left gives no press event.
        sw_raw  = 16'h0000;
        btn_raw = 5'b00000;
        apply_reset();
        btn_raw = 5'b01000;
        ticks(9);
        check_eq("rel_pressed", status, 21'h080000);
        chg_cnt_r   = 0;
        pulse_cnt_r = 0;
        btn_raw = 5'b00000;
        ticks(6);
        check_eq("rel_early", status, 21'h080000);
        tick();
        check_eq("rel_status", status, 21'h000000);
        check_eq("rel_changed", 21'(status_changed), 21'h1);
        ticks(2);
        check_eq("rel_pulse_count", 21'(pulse_cnt_r), 21'd0);
        check_eq("rel_sticky", 21'(btn_press_sticky), 21'h08);
        check_eq("rel_chg_count", 21'(chg_cnt_r), 21'd1);

        // Reset in the middle of a switch debounce.
        sw_raw = 16'h0001;
        ticks(3);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sticky", 21'(btn_press_sticky), 21'h0);
        check_eq("mid_rst_status", status, 21'h0);
        ticks(2);
        check_eq("mid_rst_hold", status, 21'h0);
        check_eq("mid_rst_changed", 21'(status_changed), 21'h0);
        rst_n = 1'b1;
        ticks(6);
        check_eq("mid_rst_early", status, 21'h000000);
        tick();
        check_eq("mid_rst_status_up", status, 21'h000001);
        check_eq("mid_rst_changed_up", 21'(status_changed), 21'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule : tb_peripheral_status_sampler
